// File: rtl/dac_cmd_arbiter.sv
// dac_cmd_arbiter: shares one SPI DAC engine between NREQ requesters, configuration word first,
// then round-robin grants with an idle gap. Define DAC_ARB_TIMEOUT_EN to enable the BUSY watchdog.
module dac_cmd_arbiter #(
    parameter int          NREQ        = 4,
    parameter logic [15:0] INIT_WORD   = 16'h9000,
    parameter int          GAP_CYC     = 1,
    parameter int          TIMEOUT_CYC = 4096,
    localparam int         LGW         = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reinit,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ack,
    output logic               da_en,
    output logic [15:0]        da_value_i,
    input  logic               da_done,
    output logic               init_done,
    output logic               busy,
    output logic [LGW-1:0]     last_grant,
    output logic [15:0]        tx_count,
    output logic               err
);

    typedef enum logic [1:0] {ST_INIT, ST_BUSY, ST_GAP, ST_IDLE} state_t;

    state_t           state_q, state_d;
    logic             da_en_q, da_en_d;
    logic [15:0]      da_value_q, da_value_d;
    logic [NREQ-1:0]  req_ack_q, req_ack_d;
    logic             init_done_q, init_done_d;
    logic [LGW-1:0]   last_grant_q, last_grant_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic             reinit_pend_q, reinit_pend_d;
    logic             cur_is_init_q, cur_is_init_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;

    logic [15:0]      req_word [NREQ];
    logic             pick_valid;
    logic [LGW-1:0]   pick_idx;
    logic [LGW-1:0]   cand;
    logic             dispatch;
    logic             wd_expire;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
            assign req_word[gi] = req_data[16*gi +: 16];
        end
    endgenerate

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;

    assign wd_expire = (state_q == ST_BUSY) && (wd_cnt_q == WDW'(TIMEOUT_CYC - 1));

    // Counter is zero outside BUSY, so it starts from zero on every entry.
    always_comb begin
        wd_cnt_d = '0;
        err_d    = err_q;
        if (state_q == ST_BUSY) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_expire && !da_done) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // Lowest k wins, so the scan effectively starts at last_grant+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = LGW'((int'(last_grant_q) + k) % NREQ);
            if (req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        da_en_d       = da_en_q;
        da_value_d    = da_value_q;
        req_ack_d     = '0;
        init_done_d   = init_done_q;
        last_grant_d  = last_grant_q;
        tx_count_d    = tx_count_q;
        reinit_pend_d = reinit_pend_q | reinit;
        cur_is_init_d = cur_is_init_q;
        gap_cnt_d     = gap_cnt_q;
        dispatch      = 1'b0;

        case (state_q)
            ST_INIT: begin
                da_value_d    = INIT_WORD;
                da_en_d       = 1'b1;
                cur_is_init_d = 1'b1;
                state_d       = ST_BUSY;
            end
            ST_BUSY: begin
                if (da_done) begin
                    da_en_d    = 1'b0;
                    tx_count_d = tx_count_q + 16'd1;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                    if (cur_is_init_q) begin
                        init_done_d = 1'b1;
                    end
                end else if (wd_expire) begin
                    da_en_d       = 1'b0;
                    reinit_pend_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end
            end
            ST_GAP: begin
                // The last gap cycle takes the IDLE decision so da_en stays low exactly GAP_CYC cycles.
                if (gap_cnt_q == 8'(GAP_CYC - 1)) begin
                    dispatch = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                dispatch = 1'b1;
            end
        endcase

        if (dispatch) begin
            if (reinit_pend_q || reinit) begin
                reinit_pend_d = 1'b0;
                init_done_d   = 1'b0;
                state_d       = ST_INIT;
            end else if (pick_valid && init_done_q) begin
                da_value_d          = req_word[pick_idx];
                da_en_d             = 1'b1;
                req_ack_d[pick_idx] = 1'b1;
                last_grant_d        = pick_idx;
                cur_is_init_d       = 1'b0;
                state_d             = ST_BUSY;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            da_en_q       <= 1'b0;
            da_value_q    <= '0;
            req_ack_q     <= '0;
            init_done_q   <= 1'b0;
            last_grant_q  <= LGW'(NREQ - 1);
            tx_count_q    <= '0;
            reinit_pend_q <= 1'b0;
            cur_is_init_q <= 1'b0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            da_en_q       <= da_en_d;
            da_value_q    <= da_value_d;
            req_ack_q     <= req_ack_d;
            init_done_q   <= init_done_d;
            last_grant_q  <= last_grant_d;
            tx_count_q    <= tx_count_d;
            reinit_pend_q <= reinit_pend_d;
            cur_is_init_q <= cur_is_init_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign da_en      = da_en_q;
    assign da_value_i = da_value_q;
    assign req_ack    = req_ack_q;
    assign init_done  = init_done_q;
    assign busy       = (state_q != ST_IDLE);
    assign last_grant = last_grant_q;
    assign tx_count   = tx_count_q;

endmodule

// File: doc/dac_cmd_arbiter.md
Name: dac_cmd_arbiter

Overview:
- Shares one SPI DAC engine between NREQ requesters (waveform generators, static-level setters).
- The engine uses the usual da_en / da_value_i / da_done handshake with 16-bit words: {4-bit command, 12-bit code}.
- After reset and on request, the block sends a configuration word first.
- It then grants requesters round-robin, one word per grant, with a guaranteed idle gap between words.

Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- INIT_WORD, 16'h9000: configuration word sent after reset or reinit.
- GAP_CYC, 1: idle cycles with da_en low between words; legal range 1..255.
- TIMEOUT_CYC, 4096: watchdog limit in BUSY (optional feature only).

Ports:
- clk  in  1  single clock; engine handshake sampled on rising edge.
- rst  in  1  asynchronous, active-high reset.
- reinit  in  1  one-cycle pulse; requests resend of INIT_WORD.
- req_valid  in  NREQ  per-requester word pending; held until ack.
- req_data  in  16*NREQ  packed words; requester i uses bits [16i+15:16i].
- req_ack  out  NREQ  one-cycle pulse; word captured.
- da_en  out  1  to DAC engine; high from launch until da_done.
- da_value_i  out  16  word to DAC engine.
- da_done  in  1  engine completion pulse.
- init_done  out  1  high once INIT_WORD has completed since the last reset/reinit.
- busy  out  1  high whenever state is not IDLE.
- last_grant  out  clog2(NREQ)  index of the most recent granted requester.
- tx_count  out  16  completed words including init; wraps 16'hFFFF->0.
- err  out  1  sticky watchdog error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values: da_en=0, da_value_i=0, req_ack=0, init_done=0, last_grant=NREQ-1, tx_count=0, err=0, state=INIT.
- Reset asserted mid-word: da_en drops immediately; INIT is resent after release.
- States: INIT, BUSY, GAP, IDLE.
- INIT: next edge sets da_value_i=INIT_WORD, da_en=1, state->BUSY, flag cur_is_init=1. No req_ack is issued.
- BUSY:
  - da_en held high and da_value_i stable.
  - On da_done=1: da_en<=0, tx_count+1, state->GAP.
  - If cur_is_init, also init_done<=1.
- GAP: counts GAP_CYC cycles with da_en low, then ->IDLE.
- IDLE, evaluated in priority order:
  1. reinit_pend set: clear it, init_done<=0, ->INIT.
  2. Otherwise, any req_valid set: pick the first set bit scanning from last_grant+1 upward modulo NREQ. In the same edge: da_value_i<=req_data[i], da_en<=1, req_ack[i]=1 for one cycle, last_grant<=i, ->BUSY.
  3. Otherwise stay in IDLE.
- Latency:
  - req_valid high in IDLE -> da_en and ack on the next rising edge.
  - da_done -> next launch is at least GAP_CYC+1 cycles later.
- reinit:
  - Pulse in any state sets reinit_pend.
  - Never aborts a word in flight; taken at the next IDLE ahead of all requests.
  - Pulse while reinit_pend is already set: no additional effect.
- Requests while init_done=0 wait; they are never dropped or acked.
- da_done outside BUSY is ignored.
- A requester deasserting req_valid before ack is not an error; its word is simply not sent.
- Fairness: with all requesters valid, grants cycle 0,1,..,NREQ-1,0. A single valid requester is granted every slot.

Optional Feature:
- Macro: DAC_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY and clears on entry.
  - If it reaches TIMEOUT_CYC without da_done: da_en<=0, err<=1 (sticky until rst), reinit_pend<=1, ->GAP. The word is not counted in tx_count.
  - A da_done arriving in the same cycle as the timeout wins; no error.
- Undefined: no counter; err tied 0; BUSY waits indefinitely.

Test Plan:
- Reset release, engine returns da_done 8 cycles after da_en -> da_en rises 1 cycle after release with 16'h9000; init_done=1 and tx_count=1 after done.
- Requests before init completes: all 4 req_valid high during init -> no ack until init_done; then acks in order 0,1,2,3,0; each da_value_i equals its req_data; da_en low for exactly 1 cycle between words.
- Single requester 2 with 16'hC7FF held -> granted every slot; last_grant=2; tx_count increments per da_done.
- reinit pulsed while BUSY on requester 1's word, req 3 valid -> word completes; INIT_WORD sent next, ahead of req 3; init_done low until that word is done.
- rst asserted mid-BUSY -> da_en low in the same cycle; after release INIT_WORD is resent; tx_count=0.
- With DAC_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, engine never responds -> da_en drops after 16 BUSY cycles, err=1, INIT_WORD retried, tx_count unchanged.
